// File: rtl/cntn_mod_ud.sv
// cntn_mod_ud: general-purpose modulo event/timebase counter.
//   - programmable modulo (count range 0..MODULO-1), up/down direction
//   - synchronous clear and parallel load (load value clipped to MODULO-1)
//   - wrap or saturate at the limits, with a built-in enable prescaler
//   - registered terminal-count pulse, sticky over/underflow flag, zero decode
// Optional feature: define CNTN_MOD_UD_CAPTURE_EN to add the capture input and
// the cap_out register, which snapshots the pre-update count on demand.
module cntn_mod_ud #(
    parameter int N      = 10,
    parameter int MODULO = 2**N,
    parameter int PRESC  = 1
) (
    input  logic         clk,
    input  logic         res,
    input  logic         enable,
    input  logic         clear,
    input  logic         up_dn,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         sat_mode,
`ifdef CNTN_MOD_UD_CAPTURE_EN
    input  logic         capture,
    output logic [N-1:0] cap_out,
`endif
    output logic [N-1:0] cnt_out,
    output logic         tc,
    output logic         ovf,
    output logic         zero
);

    // Prescaler needs at least one bit even when it never leaves 0 (PRESC=1).
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    // Top of the count range, and the modulo widened by one bit so that
    // MODULO = 2**N is representable for the load-clip comparison.
    localparam logic [N-1:0]  MAX_VAL  = N'(MODULO - 1);
    localparam logic [N:0]    MOD_EXT  = (N+1)'(MODULO);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESC - 1);

    logic [N-1:0]  cnt_r;
    logic [N-1:0]  cnt_nxt_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nxt_s;
    logic          tc_r;
    logic          tc_nxt_s;
    logic          ovf_r;
    logic          ovf_nxt_s;
    logic          presc_last_s;
    logic          step_s;

    // Clip an out-of-range load value to the top of the count range so the
    // counter can never hold a value >= MODULO.
    function automatic logic [N-1:0] clip_load(input logic [N-1:0] v);
        if ({1'b0, v} < MOD_EXT) begin
            clip_load = v;
        end else begin
            clip_load = MAX_VAL;
        end
    endfunction

    assign presc_last_s = (presc_r == PRE_LAST);
    assign step_s       = enable & presc_last_s;

    // Next-state logic: clear beats load, load beats a step, and a step at the
    // limit in the current direction is a limit event (tc pulse, sticky ovf).
    always_comb begin
        cnt_nxt_s   = cnt_r;
        presc_nxt_s = presc_r;
        tc_nxt_s    = 1'b0;
        ovf_nxt_s   = ovf_r;
        if (clear) begin
            cnt_nxt_s   = {N{1'b0}};
            presc_nxt_s = {PW{1'b0}};
            ovf_nxt_s   = 1'b0;
        end else if (load) begin
            cnt_nxt_s   = clip_load(load_val);
            presc_nxt_s = {PW{1'b0}};
        end else if (enable) begin
            if (presc_last_s) begin
                presc_nxt_s = {PW{1'b0}};
            end else begin
                presc_nxt_s = presc_r + PW'(1);
            end
            if (step_s) begin
                if (up_dn) begin
                    if (cnt_r == MAX_VAL) begin
                        tc_nxt_s  = 1'b1;
                        ovf_nxt_s = 1'b1;
                        if (sat_mode) begin
                            cnt_nxt_s = MAX_VAL;
                        end else begin
                            cnt_nxt_s = {N{1'b0}};
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + N'(1);
                    end
                end else begin
                    if (cnt_r == {N{1'b0}}) begin
                        tc_nxt_s  = 1'b1;
                        ovf_nxt_s = 1'b1;
                        if (sat_mode) begin
                            cnt_nxt_s = {N{1'b0}};
                        end else begin
                            cnt_nxt_s = MAX_VAL;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r - N'(1);
                    end
                end
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end else begin
            // enable low: count and prescaler frozen, no limit event
            cnt_nxt_s   = cnt_r;
            presc_nxt_s = presc_r;
        end
    end

    // State registers for count, prescaler and status flags.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt_r   <= {N{1'b0}};
            presc_r <= {PW{1'b0}};
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            presc_r <= presc_nxt_s;
            tc_r    <= tc_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

`ifdef CNTN_MOD_UD_CAPTURE_EN
    logic [N-1:0] cap_r;

    // Snapshot of the pre-update count; independent of clear/load/step.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cap_r <= {N{1'b0}};
        end else if (capture) begin
            cap_r <= cnt_r;
        end else begin
            cap_r <= cap_r;
        end
    end

    assign cap_out = cap_r;
`endif

    assign cnt_out = cnt_r;
    assign tc      = tc_r;
    assign ovf     = ovf_r;
    assign zero    = (cnt_r == {N{1'b0}});

endmodule
